lcd_write_ctrl: RTL and testbench
=================================

LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

Interface
REQ-001 SHALL expose parameter SETUP_CYC, default 2, meaning rs/display setup cycles before enable rises.
REQ-002 SHALL expose parameter PULSE_CYC, default 12, meaning cycles enable is held high.
REQ-003 SHALL expose parameter HOLD_CYC, default 2, meaning cycles rs/display are held after enable falls.
REQ-004 SHALL expose parameter WAIT_CYC, default 2000, meaning LCD execution wait for ordinary commands and data.
REQ-005 SHALL expose parameter CLR_WAIT_CYC, default 82000, meaning execution wait for clear/home commands.
REQ-006 SHALL expose parameter CNT_W, default 17, meaning timer width, which must hold the largest cycle parameter.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port en, input, 1, single-cycle start strobe.
REQ-010 SHALL have port instruction, input, 32, where bit 0 = rs value and bits 31:1 are ignored.
REQ-011 SHALL have port data, input, 32, where bits 7:0 = LCD byte and bits 31:8 are ignored.
REQ-012 SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at transfer end.
REQ-014 SHALL have ports rw (output, 1, tied 0), rs (output, 1), enable (output, 1), display (output, 8), the LCD pins.

Function
REQ-015 SHALL use FSM states IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-016 In IDLE, en=1 SHALL capture instruction[0] and data[7:0] into rs/display, set busy and enter SETUP on the next edge.
REQ-017 SETUP SHALL last SETUP_CYC cycles with enable=0, then PULSE SHALL last PULSE_CYC cycles with enable=1, then HOLD SHALL last HOLD_CYC cycles with enable=0 and rs/display unchanged.
REQ-018 WAIT SHALL last CLR_WAIT_CYC cycles when the captured rs=0 and data[7:1]=0 (clear/home), else WAIT_CYC cycles.
REQ-019 The cycle after WAIT ends SHALL be IDLE with done=1 and busy=0; done therefore occurs 1+SETUP_CYC+PULSE_CYC+HOLD_CYC+wait cycles after the en cycle.
REQ-020 en asserted while busy=1 SHALL be ignored with no queuing.
REQ-021 en asserted in the done cycle SHALL be accepted as a new transfer.
REQ-022 rs and display SHALL hold their last values in IDLE.
REQ-023 A parameter value of 0 SHALL be treated as 1 cycle.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, enable=0, rs=0, display=0, busy=0, done=0, timer=0, nibble flag=0.
REQ-025 Reset mid-transfer SHALL abort the transfer with no done pulse; the first en after release SHALL start a clean transfer.

Configuration
REQ-026 Macro LCD_NIBBLE_MODE_EN SHALL select the 4-bit bus mode.
REQ-027 When defined, each transfer SHALL send data[7:4] then data[3:0] on display[7:4] with display[3:0]=0: SETUP, PULSE and HOLD run for the high nibble and then again for the low nibble, followed by one WAIT, so latency = 1+2*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+wait.
REQ-028 When undefined, the 8-bit behaviour of REQ-016..REQ-019 SHALL apply and no nibble logic SHALL be synthesised.

Structure
REQ-029 Package lcd_pkg SHALL hold the FSM state typedef, the default timing constants and the clear/home detect mask constant.
REQ-030 Sub-module lcd_timer SHALL implement the loadable CNT_W-bit down-counter with a zero flag, instantiated once.

Verification (bench parameters SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=1, WAIT_CYC=5, CLR_WAIT_CYC=9)
REQ-031 en with instruction=1, data=0x41 at cycle 0 -> rs=1, display=0x41 from cycle 1; enable=1 in cycles 3-5; done=1 at cycle 12; busy=1 in cycles 1-11.
REQ-032 en with instruction=0, data=0x01 -> enable pattern as REQ-031 and done at cycle 16.
REQ-033 second en at cycle 4 of a transfer -> ignored: exactly one done pulse and display unchanged; en in the done cycle -> a new transfer starts on the next edge.
REQ-034 reset_n=0 at cycle 4 during PULSE -> enable=0 and busy=0 asynchronously, with no done pulse.
REQ-035 LCD_NIBBLE_MODE_EN defined, data=0xA5, rs=1 -> display=0xA0 with enable high in cycles 3-5, then display=0x50 with enable high in cycles 9-11, and done at cycle 18.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
// Build option: define LCD_NIBBLE_MODE_EN for the 4-bit bus variant.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_t;

  localparam int unsigned DEF_SETUP_CYC    = 2;
  localparam int unsigned DEF_PULSE_CYC    = 12;
  localparam int unsigned DEF_HOLD_CYC     = 2;
  localparam int unsigned DEF_WAIT_CYC     = 2000;
  localparam int unsigned DEF_CLR_WAIT_CYC = 82000;
  localparam int          DEF_CNT_W        = 17;

  // Clear (0x01) and home (0x00 here) commands differ only in bit 0.
  localparam logic [7:0] CLR_HOME_MASK = 8'hFE;

  // A phase of n cycles loads n-1 into the down-counter; 0 is treated as 1.
  function automatic int unsigned cyc_load(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

  function automatic logic is_clr_home(input logic rs_bit, input logic [7:0] byte_val);
    return !rs_bit && ((byte_val & CLR_HOME_MASK) == 8'h00);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter with zero flag; times every controller phase.
module lcd_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_write_ctrl.sv
// LCD write controller: sequences rs/display setup, enable pulse, hold and
// execution wait for one command/data byte per en strobe.
// Build option: LCD_NIBBLE_MODE_EN sends the byte as two nibbles on display[7:4].
module lcd_write_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC    = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned WAIT_CYC     = DEF_WAIT_CYC,
  parameter int unsigned CLR_WAIT_CYC = DEF_CLR_WAIT_CYC,
  parameter int          CNT_W        = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] instruction,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        rw,
  output logic        rs,
  output logic        enable,
  output logic [7:0]  display
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(cyc_load(SETUP_CYC));
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(cyc_load(PULSE_CYC));
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(cyc_load(HOLD_CYC));
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(cyc_load(WAIT_CYC));
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(cyc_load(CLR_WAIT_CYC));

  lcd_state_t       state, next_state;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             start;
  logic             long_wait;
  logic             unused_bits;

`ifdef LCD_NIBBLE_MODE_EN
  logic [3:0] lo_nib;
  logic       nib_lo;
`endif

  assign unused_bits = ^{instruction[31:1], data[31:8]};
  assign start       = (state == IDLE) && en;
  assign rw          = 1'b0;

  lcd_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and timer load for the phase being entered.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      IDLE: begin
        if (en) begin
          next_state = SETUP;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          next_state = PULSE;
          tmr_load   = 1'b1;
          tmr_val    = PULSE_LD;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          next_state = HOLD;
          tmr_load   = 1'b1;
          tmr_val    = HOLD_LD;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
`ifdef LCD_NIBBLE_MODE_EN
          if (!nib_lo) begin
            next_state = SETUP;
            tmr_load   = 1'b1;
            tmr_val    = SETUP_LD;
          end else begin
            next_state = WAIT;
            tmr_load   = 1'b1;
            tmr_val    = long_wait ? CLR_LD : WAIT_LD;
          end
`else
          next_state = WAIT;
          tmr_load   = 1'b1;
          tmr_val    = long_wait ? CLR_LD : WAIT_LD;
`endif
        end
      end
      WAIT: begin
        if (tmr_zero) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Pin-level outputs decoded from the current state.
  always_comb begin
    enable = (state == PULSE);
    busy   = (state != IDLE);
  end

  // Captured bus values, wait selection and the end-of-transfer pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs        <= 1'b0;
      display   <= '0;
      done      <= 1'b0;
      long_wait <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
      lo_nib    <= '0;
      nib_lo    <= 1'b0;
`endif
    end else begin
      done <= (state == WAIT) && tmr_zero;
      if (start) begin
        rs        <= instruction[0];
        long_wait <= is_clr_home(instruction[0], data[7:0]);
`ifdef LCD_NIBBLE_MODE_EN
        display   <= {data[7:4], 4'b0000};
        lo_nib    <= data[3:0];
        nib_lo    <= 1'b0;
`else
        display   <= data[7:0];
`endif
      end
`ifdef LCD_NIBBLE_MODE_EN
      // Low nibble goes out as the high-nibble hold completes.
      if ((state == HOLD) && tmr_zero && !nib_lo) begin
        nib_lo  <= 1'b1;
        display <= {lo_nib, 4'b0000};
      end
`endif
    end
  end

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl (SETUP=2, PULSE=3, HOLD=1, WAIT=5, CLR_WAIT=9).
// Covers both the 8-bit build and LCD_NIBBLE_MODE_EN.
module tb_lcd_write_ctrl;

  localparam int unsigned S_CYC = 2;
  localparam int unsigned P_CYC = 3;
  localparam int unsigned H_CYC = 1;
  localparam int unsigned W_CYC = 5;
  localparam int unsigned C_CYC = 9;
  localparam int          NVEC  = 7;

`ifdef LCD_NIBBLE_MODE_EN
  localparam logic [7:0] REQUEUE_DISP = 8'h30;
  localparam logic [7:0] IGN_DISP     = 8'h10;
  localparam int         IGN_DONE     = 18;
`else
  localparam logic [7:0] REQUEUE_DISP = 8'h33;
  localparam logic [7:0] IGN_DISP     = 8'h41;
  localparam int         IGN_DONE     = 12;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [31:0] instruction;
  logic [31:0] data;
  logic        busy, done, rw, rs, enable;
  logic [7:0]  display;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] dat;
    logic        exp_rs;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    int          exp_done;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  lcd_write_ctrl #(
    .SETUP_CYC   (S_CYC),
    .PULSE_CYC   (P_CYC),
    .HOLD_CYC    (H_CYC),
    .WAIT_CYC    (W_CYC),
    .CLR_WAIT_CYC(C_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .instruction(instruction),
    .data       (data),
    .busy       (busy),
    .done       (done),
    .rw         (rw),
    .rs         (rs),
    .enable     (enable),
    .display    (display)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_enable(input int c);
`ifdef LCD_NIBBLE_MODE_EN
    return (c >= 3 && c <= 5) || (c >= 9 && c <= 11);
`else
    return (c >= 3 && c <= 5);
`endif
  endfunction

  function automatic logic [7:0] exp_display(input vec_t v, input int c);
`ifdef LCD_NIBBLE_MODE_EN
    return (c <= 6) ? v.exp_hi : v.exp_lo;
`else
    return (c >= 0) ? v.exp_hi : v.exp_lo;
`endif
  endfunction

  // Drive one transfer and check every pin each cycle up to one past done.
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    instruction = v.instr;
    data        = v.dat;
    en          = 1'b1;
    tick();
    en          = 1'b0;
    instruction = 32'hFFFF_FFFF;
    data        = 32'hFFFF_FFFF;
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      chk($sformatf("v%0d c%0d enable", idx, c), 32'(enable), 32'(exp_enable(c)));
      chk($sformatf("v%0d c%0d busy", idx, c), 32'(busy), 32'(c < v.exp_done));
      chk($sformatf("v%0d c%0d done", idx, c), 32'(done), 32'(c == v.exp_done));
      chk($sformatf("v%0d c%0d rs", idx, c), 32'(rs), 32'(v.exp_rs));
      chk($sformatf("v%0d c%0d display", idx, c), 32'(display), 32'(exp_display(v, c)));
      chk($sformatf("v%0d c%0d rw", idx, c), 32'(rw), 32'h0);
      tick();
    end
  endtask

  initial begin
`ifdef LCD_NIBBLE_MODE_EN
    vecs[0] = '{32'h1,         32'h41,        1'b1, 8'h40, 8'h10, 18};
    vecs[1] = '{32'h0,         32'h01,        1'b0, 8'h00, 8'h10, 22};
    vecs[2] = '{32'h0,         32'h02,        1'b0, 8'h00, 8'h20, 18};
    vecs[3] = '{32'h0,         32'h00,        1'b0, 8'h00, 8'h00, 22};
    vecs[4] = '{32'h1,         32'h01,        1'b1, 8'h00, 8'h10, 18};
    vecs[5] = '{32'hFFFF_FFFE, 32'hFFFF_FF01, 1'b0, 8'h00, 8'h10, 22};
    vecs[6] = '{32'h1,         32'hA5,        1'b1, 8'hA0, 8'h50, 18};
`else
    vecs[0] = '{32'h1,         32'h41,        1'b1, 8'h41, 8'h41, 12};
    vecs[1] = '{32'h0,         32'h01,        1'b0, 8'h01, 8'h01, 16};
    vecs[2] = '{32'h0,         32'h02,        1'b0, 8'h02, 8'h02, 12};
    vecs[3] = '{32'h0,         32'h00,        1'b0, 8'h00, 8'h00, 16};
    vecs[4] = '{32'h1,         32'h01,        1'b1, 8'h01, 8'h01, 12};
    vecs[5] = '{32'hFFFF_FFFE, 32'hFFFF_FF01, 1'b0, 8'h01, 8'h01, 16};
    vecs[6] = '{32'h1,         32'hA5,        1'b1, 8'hA5, 8'hA5, 12};
`endif

    reset_n     = 1'b0;
    en          = 1'b0;
    instruction = '0;
    data        = '0;
    repeat (2) tick();
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset enable", 32'(enable), 32'h0);
    chk("reset rs", 32'(rs), 32'h0);
    chk("reset display", 32'(display), 32'h0);
    chk("reset rw", 32'(rw), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // en during a transfer is dropped: one done, display untouched.
    begin
      int dones;
      int done_at;
      dones   = 0;
      done_at = -1;
      instruction = 32'h1;
      data        = 32'h41;
      en          = 1'b1;
      tick();
      en = 1'b0;
      for (int c = 1; c <= 30; c++) begin
        if (c == 4) begin
          instruction = 32'h0;
          data        = 32'h99;
          en          = 1'b1;
        end
        if (c == 5) en = 1'b0;
        if (done) begin
          dones++;
          done_at = c;
        end
        tick();
      end
      chk("ignored en done count", 32'(dones), 32'h1);
      chk("ignored en done cycle", 32'(done_at), 32'(IGN_DONE));
      chk("ignored en display", 32'(display), 32'(IGN_DISP));
      chk("ignored en rs", 32'(rs), 32'h1);
    end

    // en in the done cycle starts the next transfer immediately.
    begin
      bit seen;
      seen        = 1'b0;
      instruction = 32'h1;
      data        = 32'h41;
      en          = 1'b1;
      tick();
      en = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
        if (done) begin
          seen        = 1'b1;
          instruction = 32'h1;
          data        = 32'h33;
          en          = 1'b1;
        end
        tick();
      end
      en = 1'b0;
      chk("done-cycle en seen done", 32'(seen), 32'h1);
      chk("done-cycle en busy", 32'(busy), 32'h1);
      chk("done-cycle en display", 32'(display), 32'(REQUEUE_DISP));
      chk("done-cycle en rs", 32'(rs), 32'h1);
      seen = 1'b0;
      for (int c = 0; c <= 40 && !seen; c++) begin
        if (done) seen = 1'b1;
        tick();
      end
      chk("done-cycle en second done", 32'(seen), 32'h1);
    end

    // Asynchronous reset in PULSE aborts with no done.
    begin
      int dones;
      dones       = 0;
      instruction = 32'h1;
      data        = 32'h41;
      en          = 1'b1;
      tick();
      en = 1'b0;
      repeat (3) tick();
      chk("pre-reset enable", 32'(enable), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("async reset enable", 32'(enable), 32'h0);
      chk("async reset busy", 32'(busy), 32'h0);
      chk("async reset display", 32'(display), 32'h0);
      chk("async reset rs", 32'(rs), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
        if (done) dones++;
        tick();
      end
      chk("post-reset no done", 32'(dones), 32'h0);
      chk("post-reset idle busy", 32'(busy), 32'h0);
      run_vec(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
